// File: rtl/rr_mux16_pkg.sv
// Shared constants and state encoding for the rr_mux16 round-robin gatherer.
package rr_mux16_pkg;

  localparam int NCH  = 16;
  localparam int SELW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/rr_mux16_if.sv
// Source-bank and consumer handshake bundle for rr_mux16.
interface rr_mux16_if
  import rr_mux16_pkg::*;
#(
  parameter int WIDTH = 16
);

  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_ack;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;
  logic                 out_valid;
  logic                 out_ready;

  // master is the multiplexer itself; slave is the producer bank plus consumer
  modport master (
    input  in_valid, in_data, out_ready,
    output in_ack, out_data, out_sel, out_valid
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ack, out_data, out_sel, out_valid
  );

endinterface

// File: rtl/rr_mux16_pick16.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick16
  import rr_mux16_pkg::*;
(
  input  logic [NCH-1:0]  req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic            any_o,
  output logic [SELW-1:0] idx_o
);

  logic [2*NCH-1:0] dbl;
  logic [NCH-1:0]   rot;
  logic [SELW-1:0]  off;

  // rotating right by ptr puts the highest-priority channel at bit 0
  assign dbl = {req_i, req_i} >> ptr_i;
  assign rot = dbl[NCH-1:0];

  always_comb begin
    off = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot[i]) off = i[SELW-1:0];
    end
  end

  assign any_o = |req_i;
  assign idx_o = off + ptr_i;

endmodule

// File: rtl/rr_mux16.sv
// Sequential 16-to-1 round-robin gathering mux with registered valid/ready output
// and a one-cycle ack back to the granted source.
//
// state | meaning
// IDLE  | output stage empty, out_valid low
// HOLD  | word latched, out_valid high until accepted
module rr_mux16
  import rr_mux16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic rst,
  rr_mux16_if.master bus
);

  state_e          state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [NCH-1:0]  ack_q, ack_d;

  logic [NCH-1:0]  eligible;
  logic            any_req;
  logic [SELW-1:0] pick;
  logic            load;

  // a source still seeing its ack has not yet had a chance to drop its request
  assign eligible = bus.in_valid & ~ack_q;

  rr_pick16 u_pick (
    .req_i (eligible),
    .ptr_i (ptr_q),
    .any_o (any_req),
    .idx_o (pick)
  );

  assign load = any_req && ((state_q == IDLE) || bus.out_ready);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ack_d   = '0;
    if (load) begin
      data_d  = bus.in_data[pick*WIDTH +: WIDTH];
      sel_d   = pick;
      ack_d   = NCH'(1) << pick;
      ptr_d   = pick + SELW'(1);
      state_d = HOLD;
    end else if (state_q == HOLD && bus.out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.in_ack    = ack_q;

endmodule

// File: tb/tb_rr_mux16.sv
// Directed self-checking bench for rr_mux16.
module tb_rr_mux16;
  import rr_mux16_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [W-1:0] word [NCH];

  rr_mux16_if #(.WIDTH(W)) bus ();

  rr_mux16 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_words();
    for (int i = 0; i < NCH; i++) bus.in_data[i*W +: W] = word[i];
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) word[i] = 16'hA000 + W'(i);
    word[3] = 16'hBEEF;
    load_words();
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_sel",   {28'd0, bus.out_sel},   32'd0);
    chk("rst_ack",   {16'd0, bus.in_ack},    32'd0);
    chk("rst_data",  {16'd0, bus.out_data},  32'd0);
    rst = 1'b0;
    tick();

    // single request on channel 3
    bus.in_valid = 16'h0008;
    tick();
    chk("single_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("single_sel",   {28'd0, bus.out_sel},   32'd3);
    chk("single_data",  {16'd0, bus.out_data},  32'h0000BEEF);
    chk("single_ack",   {16'd0, bus.in_ack},    32'h00000008);
    bus.in_valid = '0;
    tick();
    chk("single_drop_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("single_drop_ack",   {16'd0, bus.in_ack},    32'd0);

    // round robin from ptr=0 with every channel requesting
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 16'hFFFF;
    for (int n = 0; n < 17; n++) begin
      tick();
      chk($sformatf("rr_valid_%0d", n), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("rr_sel_%0d", n),   {28'd0, bus.out_sel},   32'(n % 16));
      chk($sformatf("rr_ack_%0d", n),   {16'd0, bus.in_ack},    32'd1 << (n % 16));
      chk($sformatf("rr_data_%0d", n),  {16'd0, bus.out_data},  {16'd0, word[n % 16]});
    end
    bus.in_valid = '0;
    tick();
    chk("rr_idle", {31'd0, bus.out_valid}, 32'd0);

    // wrap-around: grant 14, then channels 14 and 0 compete with ptr=15
    bus.in_valid = 16'h4000;
    tick();
    chk("wrap_g14", {28'd0, bus.out_sel}, 32'd14);
    bus.in_valid = '0;
    tick();
    chk("wrap_idle", {31'd0, bus.out_valid}, 32'd0);
    bus.in_valid = 16'h4001;
    tick();
    chk("wrap_sel", {28'd0, bus.out_sel}, 32'd0);
    chk("wrap_ack", {16'd0, bus.in_ack},  32'h00000001);
    bus.in_valid = '0;
    tick();

    // backpressure holding channel 2
    bus.in_valid = 16'h0004;
    tick();
    chk("bp_grant", {28'd0, bus.out_sel}, 32'd2);
    bus.out_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      case (n)
        0: bus.in_valid = 16'hFFFF;
        1: bus.in_valid = 16'h00F0;
        2: bus.in_valid = 16'h0001;
        default: bus.in_valid = 16'h0000;
      endcase
      tick();
      chk($sformatf("bp_valid_%0d", n), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("bp_sel_%0d", n),   {28'd0, bus.out_sel},   32'd2);
      chk($sformatf("bp_data_%0d", n),  {16'd0, bus.out_data},  {16'd0, word[2]});
      chk($sformatf("bp_ack_%0d", n),   {16'd0, bus.in_ack},    32'd0);
    end
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release", {31'd0, bus.out_valid}, 32'd0);

    // ack masking: channel 5 requesting continuously
    bus.in_valid = 16'h0020;
    for (int n = 0; n < 6; n++) begin
      tick();
      chk($sformatf("mask_valid_%0d", n), {31'd0, bus.out_valid}, (n % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("mask_ack_%0d", n),   {16'd0, bus.in_ack},    (n % 2 == 0) ? 32'h20 : 32'd0);
    end
    tick();
    chk("mask_hold_sel", {28'd0, bus.out_sel}, 32'd5);

    // asynchronous reset while holding channel 5
    bus.out_ready = 1'b0;
    tick();
    chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_sel",   {28'd0, bus.out_sel},   32'd0);
    chk("arst_ack",   {16'd0, bus.in_ack},    32'd0);
    chk("arst_data",  {16'd0, bus.out_data},  32'd0);
    tick();
    rst = 1'b0;
    bus.in_valid  = 16'h0001;
    bus.out_ready = 1'b1;
    tick();
    chk("post_rst_sel", {28'd0, bus.out_sel}, 32'd0);
    chk("post_rst_ack", {16'd0, bus.in_ack},  32'h00000001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_mux16.md
Name: rr_mux16

Overview:
- Sequential 16-to-1 gathering multiplexer; the collecting counterpart to the 1-to-16 demux16 distribution path.
- Sixteen source channels each present a data word with a valid flag.
- The block grants one channel at a time in round-robin order and latches its word into a registered output stage. It emits the word with its 4-bit channel index under a valid/ready handshake, and sends a one-cycle ack back to the granted source.
- Sits between a bank of 16 producers and a single shared consumer (bus, serializer, or demux16 on the far side).

Parameters:
- WIDTH, 16, data word width per channel.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  16  bit i high: channel i holds a word to send.
- in_data  input  16*WIDTH  channel i word at bits [i*WIDTH +: WIDTH].
- in_ack  output  16  one-hot, one-cycle pulse: channel i word captured.
- out_data  output  WIDTH  captured word.
- out_sel  output  4  index of the channel out_data came from.
- out_valid  output  1  out_data/out_sel valid.
- out_ready  input  1  consumer accepts when out_valid and out_ready are both high at a rising edge.

Behaviour:
- Reset, asynchronous and immediate, also mid-transfer:
  - out_valid=0, out_data=0, out_sel=0, in_ack=0.
  - Round-robin pointer ptr=0; state=IDLE.
  - Any held word is discarded; no ack is issued for it.
- ptr (4 bits) is the highest-priority index. After each grant ptr = granted index + 1 mod 16, so 15 wraps to 0.
- Pick function: the first set bit of the eligible mask, scanning ptr, ptr+1, ... 15, 0, ... ptr-1.
  - Eligible = in_valid with the bit of any channel whose in_ack is currently high cleared.
  - Masking prevents re-granting a source that has not yet seen its ack.
- Load condition L = (state==IDLE) or (state==HOLD and out_ready). The eligible mask must also be non-zero.
- State IDLE, out_valid=0:
  - On L: out_data <= word of picked channel k; out_sel <= k; out_valid <= 1; in_ack <= one-hot(k); ptr <= k+1; go to HOLD.
  - Otherwise: stay in IDLE; in_ack <= 0.
- State HOLD, out_valid=1:
  - out_data and out_sel stay stable until accepted.
  - in_ack <= 0 every cycle except a load cycle.
  - out_ready=1 with an eligible request: back-to-back load of the next word (same actions as IDLE load); stay in HOLD; no bubble.
  - out_ready=1 with no eligible request: out_valid <= 0; go to IDLE.
  - out_ready=0: hold everything.
- Latency:
  - Request in IDLE at edge t gives out_valid and in_ack high after edge t.
  - Sustained throughput is 1 word/cycle while out_ready stays high and requests remain.
- in_ack rises together with out_valid/out_sel for the same grant and lasts exactly 1 cycle.
  - Sources must drop or advance in_valid on the edge following in_ack.
- A single continuously requesting channel with out_ready=1 gets at most every other cycle, because of ack masking.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Shared package:
  - constants NCH=16 and SELW=4;
  - state encoding IDLE=1'b0, HOLD=1'b1.
- One sub-module: rr_pick16, purely combinational.
  - Inputs: 16-bit request mask and 4-bit ptr.
  - Outputs: any flag and 4-bit index.
  - Implementation: rotate right by ptr, priority-encode the lowest set bit, add ptr mod 16.

Test Plan:
- Reset mid-HOLD (out_valid=1, out_sel=5):
  - assert rst between edges -> out_valid, in_ack, out_sel drop to 0 immediately;
  - after release with in_valid=16'h0001 -> out_sel=0.
- Single request, in_valid=16'h0008, data 16'hBEEF, out_ready=1:
  - next edge -> out_valid=1, out_sel=3, out_data=16'hBEEF, in_ack=16'h0008 for one cycle;
  - following edge -> out_valid=0.
- Round-robin order, in_valid=16'hFFFF held, out_ready=1:
  - -> out_sel sequence 0,1,2,...,15,0 on consecutive cycles;
  - in_ack walks one-hot in step.
- Wrap-around: after a grant of 14, in_valid=16'h4001 (channels 14 and 0) -> next grant 0, not 14; ptr wraps 15 to 0 correctly.
- Backpressure: in HOLD with out_sel=2, hold out_ready=0 for 4 cycles while in_valid changes -> out_data/out_sel unchanged, in_ack=0, no new grant.
- Ack masking: in_valid=16'h0020 held high through the ack cycle, out_ready=1 -> channel 5 granted on alternate cycles only, never on the cycle its ack is high.
